// File: rtl/ifm_out_fsm_pkg.sv
// Shared definitions for the receive drain stage: state encodings and FIFO word field offsets.
package ifm_out_fsm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  localparam int DATA_W       = 73;
  localparam int LAST_BIT     = 72;
  localparam int KEEP_MSB     = 71;
  localparam int KEEP_LSB     = 64;
  localparam int INFO_BAD_BIT = 0;

endpackage

// File: rtl/ifm_keep_popcnt.sv
// Combinational byte-enable popcount: 8-bit keep to 4-bit byte count, no latency.
module ifm_keep_popcnt (
  input  logic [7:0] keep_i,
  output logic [3:0] cnt_o
);

  always_comb begin
    cnt_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt_o = cnt_o + {3'b000, keep_i[i]};
    end
  end

endmodule

// File: rtl/ifm_out_fsm.sv
// Drains receive FIFOs: forwards good frames on AXI4-Stream (1-cycle registered output), drops bad ones,
// reports forwarded byte length. Optional frame counters under IFM_OUT_STATS_EN.
module ifm_out_fsm
  import ifm_out_fsm_pkg::*;
#(
  parameter int C_LEN_W = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [72:0]        data_fifo_rdata,
  input  logic               data_fifo_empty,
  output logic               data_fifo_rden,
  input  logic [7:0]         info_fifo_rdata,
  input  logic               info_fifo_empty,
  output logic               info_fifo_rden,
  output logic [63:0]        m_axis_tdata,
  output logic [7:0]         m_axis_tkeep,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               frame_len_valid,
  output logic [C_LEN_W-1:0] frame_len,
  output logic [3:0]         ifm_out_fsm_dbg
`ifdef IFM_OUT_STATS_EN
  ,
  output logic [31:0]        stat_good_frames,
  output logic [31:0]        stat_bad_frames
`endif
);

  state_t             state_q, state_d;
  logic [C_LEN_W-1:0] acc_q, acc_d;
  logic [63:0]        tdata_q;
  logic [7:0]         tkeep_q;
  logic               tlast_q, tvalid_q;
  logic               flv_q;
  logic [C_LEN_W-1:0] flen_q;
  logic               pass_pop;
  logic               word_last;
  logic [3:0]         keep_cnt;
  logic [C_LEN_W:0]   acc_sum;
  logic               unused_info;

  assign word_last   = data_fifo_rdata[LAST_BIT];
  assign unused_info = ^info_fifo_rdata[7:1];

  ifm_keep_popcnt u_popcnt (
    .keep_i (data_fifo_rdata[KEEP_MSB:KEEP_LSB]),
    .cnt_o  (keep_cnt)
  );

  // One extra bit of headroom detects overflow so the total pins at all-ones.
  assign acc_sum = {1'b0, acc_q} + {{(C_LEN_W-3){1'b0}}, keep_cnt};

  always_comb begin
    state_d        = state_q;
    info_fifo_rden = 1'b0;
    data_fifo_rden = 1'b0;
    pass_pop       = 1'b0;
    acc_d          = acc_q;
    case (state_q)
      S_IDLE: begin
        acc_d = '0;
        if (!info_fifo_empty) begin
          info_fifo_rden = 1'b1;
          state_d        = info_fifo_rdata[INFO_BAD_BIT] ? S_DROP : S_PASS;
        end
      end
      S_PASS: begin
        pass_pop       = !data_fifo_empty && (!tvalid_q || m_axis_tready);
        data_fifo_rden = pass_pop;
        if (pass_pop) begin
          acc_d = acc_sum[C_LEN_W] ? '1 : acc_sum[C_LEN_W-1:0];
          if (word_last) state_d = S_IDLE;
        end
      end
      S_DROP: begin
        data_fifo_rden = !data_fifo_empty;
        if (!data_fifo_empty && word_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      flv_q    <= 1'b0;
      flen_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      flv_q   <= pass_pop && word_last;
      if (pass_pop && word_last) flen_q <= acc_d;
      // A pending last beat may still drain while the FSM has already returned to idle.
      if (pass_pop) begin
        tdata_q  <= data_fifo_rdata[63:0];
        tkeep_q  <= data_fifo_rdata[KEEP_MSB:KEEP_LSB];
        tlast_q  <= word_last;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

`ifdef IFM_OUT_STATS_EN
  logic [31:0] good_q, bad_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      if (pass_pop && word_last) good_q <= good_q + 32'd1;
      if (info_fifo_rden && info_fifo_rdata[INFO_BAD_BIT]) bad_q <= bad_q + 32'd1;
    end
  end

  assign stat_good_frames = good_q;
  assign stat_bad_frames  = bad_q;
`endif

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tkeep    = tkeep_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tvalid   = tvalid_q;
  assign frame_len_valid = flv_q;
  assign frame_len       = flen_q;
  assign ifm_out_fsm_dbg = {2'b00, state_q};

endmodule

// File: tb/tb_ifm_out_fsm.sv
// Directed bench for ifm_out_fsm with FWFT FIFO models; a second instance with C_LEN_W=12 runs in lockstep.
module tb_ifm_out_fsm;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_empty, data_fifo_rden;
  logic [7:0]  info_fifo_rdata;
  logic        info_fifo_empty, info_fifo_rden;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        frame_len_valid;
  logic [15:0] frame_len;
  logic [3:0]  dbg;

  logic        s_data_rden, s_info_rden;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast, s_tvalid, s_flv;
  logic [11:0] s_flen;
  logic [3:0]  s_dbg;
`ifdef IFM_OUT_STATS_EN
  logic [31:0] stat_good, stat_bad, s_good, s_bad;
`endif

  always #5 sys_clk = ~sys_clk;

  logic [72:0] d_mem [0:2047];
  logic [7:0]  i_mem [0:15];
  int d_wr = 0, d_rd = 0, i_wr = 0, i_rd = 0;

  assign data_fifo_rdata = d_mem[d_rd];
  assign data_fifo_empty = (d_rd == d_wr);
  assign info_fifo_rdata = i_mem[i_rd];
  assign info_fifo_empty = (i_rd == i_wr);

  ifm_out_fsm #(.C_LEN_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .data_fifo_rdata(data_fifo_rdata), .data_fifo_empty(data_fifo_empty), .data_fifo_rden(data_fifo_rden),
    .info_fifo_rdata(info_fifo_rdata), .info_fifo_empty(info_fifo_empty), .info_fifo_rden(info_fifo_rden),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .frame_len_valid(frame_len_valid), .frame_len(frame_len), .ifm_out_fsm_dbg(dbg)
`ifdef IFM_OUT_STATS_EN
    , .stat_good_frames(stat_good), .stat_bad_frames(stat_bad)
`endif
  );

  ifm_out_fsm #(.C_LEN_W(12)) u_sat (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .data_fifo_rdata(data_fifo_rdata), .data_fifo_empty(data_fifo_empty), .data_fifo_rden(s_data_rden),
    .info_fifo_rdata(info_fifo_rdata), .info_fifo_empty(info_fifo_empty), .info_fifo_rden(s_info_rden),
    .m_axis_tdata(s_tdata), .m_axis_tkeep(s_tkeep), .m_axis_tlast(s_tlast),
    .m_axis_tvalid(s_tvalid), .m_axis_tready(m_axis_tready),
    .frame_len_valid(s_flv), .frame_len(s_flen), .ifm_out_fsm_dbg(s_dbg)
`ifdef IFM_OUT_STATS_EN
    , .stat_good_frames(s_good), .stat_bad_frames(s_bad)
`endif
  );

  // Monitor: FIFO pops, accepted beats, length pulses, flow-control rules.
  logic [63:0] ob_dat [0:2047];
  logic [7:0]  ob_keep [0:2047];
  logic        ob_last [0:2047];
  int          ob_cyc [0:2047];
  int n_out = 0, cyc = 0, n_pulse = 0, n_viol = 0, n_unstab = 0, n_desync = 0;
  logic [15:0] last_len = '0;
  logic        chk_en = 1'b0, prev_stall = 1'b0;
  logic [72:0] prev_beat = '0;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (data_fifo_rden) d_rd <= d_rd + 1;
    if (info_fifo_rden) i_rd <= i_rd + 1;
    if (s_data_rden !== data_fifo_rden || s_info_rden !== info_fifo_rden) n_desync <= n_desync + 1;
    if (m_axis_tvalid && m_axis_tready) begin
      ob_dat[n_out]  <= m_axis_tdata;
      ob_keep[n_out] <= m_axis_tkeep;
      ob_last[n_out] <= m_axis_tlast;
      ob_cyc[n_out]  <= cyc;
      n_out <= n_out + 1;
    end
    if (frame_len_valid) begin
      n_pulse  <= n_pulse + 1;
      last_len <= frame_len;
    end
    if (chk_en && data_fifo_rden && m_axis_tvalid && !m_axis_tready) n_viol <= n_viol + 1;
    if (chk_en && prev_stall &&
        (!m_axis_tvalid || {m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== prev_beat))
      n_unstab <= n_unstab + 1;
    prev_stall <= m_axis_tvalid && !m_axis_tready;
    prev_beat  <= {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int n, input logic [7:0] last_keep, input logic [31:0] tag);
    for (int i = 0; i < n; i++) begin
      d_mem[d_wr] = {(i == n - 1), (i == n - 1) ? last_keep : 8'hFF, tag, i[31:0]};
      d_wr++;
    end
  endtask

  task automatic push_info(input logic [7:0] v);
    i_mem[i_wr] = v;
    i_wr++;
  endtask

  task automatic wait_drain(input int budget, input bit toggle, input string tag);
    int k = 0;
    logic [3:0] pat = 4'b1001;
    while (!(d_rd == d_wr && i_rd == i_wr && dbg == 4'd0 && !m_axis_tvalid) && k < budget) begin
      if (toggle) m_axis_tready = pat[k % 4];
      @(negedge sys_clk);
      k++;
    end
    m_axis_tready = 1'b1;
    chk(tag, {63'd0, k < budget}, 64'd1);
  endtask

  initial begin
    int n0, p0, r0, k;

    // Reset state while sys_rst is held.
    #1;
    chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_state", {60'd0, dbg}, 64'd0);
    chk("rst_flv", {63'd0, frame_len_valid}, 64'd0);
    chk("rst_flen", {48'd0, frame_len}, 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // 1: good 3-beat frame, keep FF FF 0F -> 20 bytes.
    n0 = n_out; p0 = n_pulse;
    push_frame(3, 8'h0F, 32'h11);
    push_info(8'h00);
    wait_drain(20, 1'b0, "t1_timeout");
    @(negedge sys_clk);
    chk("t1_beats", n_out - n0, 3);
    chk("t1_dat0", ob_dat[n0], {32'h11, 32'd0});
    chk("t1_dat2", ob_dat[n0+2], {32'h11, 32'd2});
    chk("t1_keep2", {56'd0, ob_keep[n0+2]}, 64'h0F);
    chk("t1_last", {62'd0, ob_last[n0+1], ob_last[n0+2]}, 64'b01);
    chk("t1_b2b", ob_cyc[n0+2] - ob_cyc[n0], 2);
    chk("t1_len", {48'd0, last_len}, 64'd20);
    chk("t1_pulses", n_pulse - p0, 1);
    chk("t1_info_pops", i_rd, 1);

    // 2: bad 4-beat frame dropped, then good 1-beat frame keep 01.
    n0 = n_out; p0 = n_pulse;
    push_frame(4, 8'hFF, 32'h22);
    push_info(8'h01);
    push_frame(1, 8'h01, 32'h23);
    push_info(8'h00);
    wait_drain(30, 1'b0, "t2_timeout");
    @(negedge sys_clk);
    chk("t2_beats", n_out - n0, 1);
    chk("t2_dat", ob_dat[n0], {32'h23, 32'd0});
    chk("t2_len", {48'd0, last_len}, 64'd1);
    chk("t2_pulses", n_pulse - p0, 1);
    chk("t2_drained", d_wr - d_rd, 0);
`ifdef IFM_OUT_STATS_EN
    chk("t2_stat_good", stat_good, 2);
    chk("t2_stat_bad", stat_bad, 1);
`endif

    // 3: 4 beats with tready toggling 1,0,0,1.
    n0 = n_out;
    chk_en = 1'b1;
    push_frame(4, 8'hFF, 32'h33);
    push_info(8'h00);
    wait_drain(60, 1'b1, "t3_timeout");
    chk_en = 1'b0;
    @(negedge sys_clk);
    chk("t3_beats", n_out - n0, 4);
    for (int i = 0; i < 4; i++) chk("t3_order", ob_dat[n0+i], {32'h33, i[31:0]});
    chk("t3_len", {48'd0, last_len}, 64'd32);
    chk("t3_rden_stall", n_viol, 0);
    chk("t3_stable", n_unstab, 0);

    // 4: data present, info absent -> nothing moves; info arrives -> tvalid within 2 cycles.
    n0 = n_out; r0 = d_rd;
    push_frame(2, 8'h80, 32'h44);
    repeat (5) @(negedge sys_clk);
    chk("t4_no_data_pop", d_rd - r0, 0);
    chk("t4_no_out", n_out - n0, 0);
    chk("t4_idle", {60'd0, dbg}, 64'd0);
    push_info(8'h00);
    repeat (2) @(negedge sys_clk);
    chk("t4_start", {63'd0, m_axis_tvalid}, 64'd1);
    wait_drain(20, 1'b0, "t4_timeout");
    @(negedge sys_clk);
    chk("t4_len", {48'd0, last_len}, 64'd9);

    // 5: 1100 x 8 bytes -> 8800; 12-bit instance saturates at 4095.
    n0 = n_out;
    push_frame(1100, 8'hFF, 32'h55);
    push_info(8'h00);
    wait_drain(1300, 1'b0, "t5_timeout");
    @(negedge sys_clk);
    chk("t5_beats", n_out - n0, 1100);
    chk("t5_len16", {48'd0, last_len}, 64'd8800);
    chk("t5_len12", {52'd0, s_flen}, 64'd4095);
    chk("t5_lockstep", n_desync, 0);

    // 6: async reset mid-frame with a stalled beat.
    m_axis_tready = 1'b0;
    push_frame(3, 8'h0F, 32'h66);
    push_info(8'h00);
    k = 0;
    while (!m_axis_tvalid && k < 10) begin @(negedge sys_clk); k++; end
    chk("t6_tvalid_up", {63'd0, m_axis_tvalid}, 64'd1);
    #2 sys_rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("t6_rst_state", {60'd0, dbg}, 64'd0);
    chk("t6_rst_flv", {63'd0, frame_len_valid}, 64'd0);
    chk("t6_rst_flen", {48'd0, frame_len}, 64'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    m_axis_tready = 1'b1;
    r0 = d_rd; n0 = n_out;
    repeat (5) @(negedge sys_clk);
    chk("t6_no_pop", d_rd - r0, 0);
    chk("t6_no_out", n_out - n0, 0);
    push_info(8'h00);
    wait_drain(20, 1'b0, "t6_timeout");
    @(negedge sys_clk);
    chk("t6_resume_beats", n_out - n0, 2);
    chk("t6_resume_dat", ob_dat[n0], {32'h66, 32'd1});
    chk("t6_resume_len", {48'd0, last_len}, 64'd12);
`ifdef IFM_OUT_STATS_EN
    chk("t6_stat_good", stat_good, 1);
    chk("t6_stat_bad", stat_bad, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
